int_controller: RTL
===================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NIRQ, default 4, number of interrupt sources (2..8).
REQ-002 Parameter VEC_WIDTH, default 10, PC/vector width in bits.
REQ-003 Parameter VEC_BASE, default 10'h380, address of source-0 vector.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 irq  input  NIRQ  external interrupt lines; a rising edge is one event.
REQ-007 mask_we  input  1  mask register write enable.
REQ-008 mask_d  input  NIRQ  new mask value; bit=1 enables the source.
REQ-009 mask_q  output  NIRQ  current mask register.
REQ-010 pending_q  output  NIRQ  latched, unserviced events.
REQ-011 int_req  output  1  interrupt request to the control unit.
REQ-012 int_vec  output  VEC_WIDTH  handler address; valid while int_req=1.
REQ-013 int_ack  input  1  control unit accepts the request (one-cycle pulse).
REQ-014 pc_in  input  VEC_WIDTH  return address presented with int_ack.
REQ-015 epc  output  VEC_WIDTH  saved return address.
REQ-016 int_ret  input  1  return-from-interrupt executed (one-cycle pulse).
REQ-017 int_busy  output  1  handler in progress.

Function
REQ-018 Edge detect: irq_s = irq (or its synchronised copy, see REQ-034); pending[i] is set on the edge where irq_s[i]=1 and the previous-cycle sample was 0; level-high without an edge does not set it.
REQ-019 Active set = pending_q & mask_q; the winner is the lowest-index active bit (isolated with a & -a); index i yields vector VEC_BASE + 4*i.
REQ-020 FSM states: IDLE, REQ, SERV; encoding is free.
REQ-021 IDLE: if the active set is nonzero, latch the one-hot winner into sel and go to REQ; otherwise stay.
REQ-022 REQ: int_req=1 and int_vec reflects sel; sel is frozen in this state, and later higher-priority events or mask writes neither change nor withdraw the request.
REQ-023 REQ with int_ack=1: epc<=pc_in, pending[sel] cleared, go to SERV; int_req=0 from the next cycle.
REQ-024 SERV: int_busy=1, no new requests (no nesting); int_ret=1 goes to IDLE, and pending work is re-evaluated on the next cycle.
REQ-025 int_ack outside REQ and int_ret outside SERV are ignored.
REQ-026 A new edge on source i in the same cycle that pending[i] is cleared leaves pending[i]=1 (set wins).
REQ-027 Events arriving during REQ/SERV are latched and serviced after return, in priority order.
REQ-028 mask_we takes effect on the next edge; masked sources still latch pending.
REQ-029 Latency (no sync): irq rising before edge k gives pending=1 after k and int_req=1 after k+1.
REQ-030 Outputs are registered or decoded from registers only; no combinational path from int_ack/int_ret to int_req.

Reset
REQ-031 Reset clears mask_q, pending_q, sel, epc and the edge-detect/sync flops to 0; state returns to IDLE; int_req=0, int_busy=0, int_vec=VEC_BASE.
REQ-032 Reset mid-REQ or mid-SERV drops the request and busy immediately, and the in-flight event is lost.
REQ-033 irq held high across reset release does not create an event.

Configuration
REQ-034 Macro INT_SYNC_EN: when defined, each irq bit passes through a two-flop synchroniser before edge detect, adding 2 cycles to REQ-029 latency; when undefined, irq is sampled directly.

Verification
REQ-035 Write mask=4'b0001, pulse irq[0] (no sync) -> pending[0]=1 after edge k, int_req=1 after k+1, int_vec=10'h380.
REQ-036 Write mask=4'b1111, raise irq[3] and irq[1] in the same cycle -> int_vec=10'h384; after ack with pc_in=10'h055 and ret, int_vec=10'h38C; epc=10'h055 after the first ack.
REQ-037 In REQ for source 2, raise irq[0] -> int_vec stays 10'h388 until ack; source 0 is requested one cycle after int_ret.
REQ-038 mask=0, pulse irq[1] -> pending_q=4'b0010 and int_req stays 0; then write mask=4'b0010 -> int_req=1 two edges later.
REQ-039 Assert reset during SERV -> int_busy=0, pending_q=0, mask_q=0, epc=0; stray int_ret is ignored afterwards.
REQ-040 With INT_SYNC_EN defined, repeat REQ-035 -> int_req=1 after edge k+3.

Source files
------------

// File: rtl/int_controller.sv
// int_controller -- prioritised, non-nesting interrupt controller.
//
// Rising edges on irq latch into pending_q. The lowest-index pending source
// whose mask bit is set wins. Its handler address goes out as
// VEC_BASE + 4*index on int_vec, and int_req is held high. While int_req is
// high, the selection does not change.
//
// int_ack does three things:
//   - saves pc_in into epc,
//   - clears the serviced pending bit,
//   - marks the handler busy until int_ret.
//
// Parameters:
//   NIRQ      number of interrupt sources (2..8)
//   VEC_WIDTH PC / vector width
//   VEC_BASE  vector address of source 0
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   irq           external interrupt lines (rising edge = event)
//   mask_we/_d    mask register write port; mask_q current mask (1 = enabled)
//   pending_q     latched, unserviced events
//   int_req       request to the control unit
//   int_vec       handler address
//   int_ack       request accepted
//   pc_in         return address captured on int_ack
//   epc           saved return address
//   int_ret       return from interrupt
//   int_busy      handler in progress
//
// Optional feature:
//   Define INT_SYNC_EN to pass each irq bit through a two-flop synchroniser
//   before edge detection. This adds two cycles of latency.
module int_controller #(
    parameter int                   NIRQ      = 4,
    parameter int                   VEC_WIDTH = 10,
    parameter logic [VEC_WIDTH-1:0] VEC_BASE  = 10'h380
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIRQ-1:0]      irq,
    input  logic                 mask_we,
    input  logic [NIRQ-1:0]      mask_d,
    output logic [NIRQ-1:0]      mask_q,
    output logic [NIRQ-1:0]      pending_q,
    output logic                 int_req,
    output logic [VEC_WIDTH-1:0] int_vec,
    input  logic                 int_ack,
    input  logic [VEC_WIDTH-1:0] pc_in,
    output logic [VEC_WIDTH-1:0] epc,
    input  logic                 int_ret,
    output logic                 int_busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERV
    } state_t;

    state_t               state_q;
    logic [NIRQ-1:0]      sel_q;
    logic [VEC_WIDTH-1:0] vec_q;
    logic [VEC_WIDTH-1:0] epc_q;
    logic [NIRQ-1:0]      irq_s;
    logic [NIRQ-1:0]      irq_prev;
    logic [NIRQ-1:0]      rise;
    logic [NIRQ-1:0]      active;
    logic [NIRQ-1:0]      winner;
    logic [VEC_WIDTH-1:0] win_vec;
    logic [NIRQ-1:0]      clr;
    logic [1:0]           warm_q;
    logic                 armed;

`ifdef INT_SYNC_EN
    localparam int unsigned WARM = 3;
    logic [NIRQ-1:0] sync1_q;
    logic [NIRQ-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    localparam int unsigned WARM = 1;
    assign irq_s = irq;
`endif

    // After reset, edges are ignored until the sampling pipeline has seen
    // real irq levels. This stops a line held high across reset release
    // from looking like a fresh rising edge.
    assign armed = (warm_q == 2'(WARM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q   <= '0;
            irq_prev <= '0;
        end else begin
            if (!armed) begin
                warm_q <= warm_q + 2'd1;
            end
            irq_prev <= irq_s;
        end
    end

    assign rise = armed ? (irq_s & ~irq_prev) : '0;

    // Lowest-index active source, isolated as a & -a.
    assign active = pending_q & mask_q;
    assign winner = active & (~active + NIRQ'(1));

    always_comb begin
        win_vec = VEC_BASE;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (winner[i]) begin
                win_vec = VEC_BASE + VEC_WIDTH'(4 * i);
            end
        end
    end

    // A new edge in the same cycle as the clear wins.
    assign clr = (state_q == REQ && int_ack) ? sel_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            vec_q   <= VEC_BASE;
            epc_q   <= '0;
            mask_q  <= '0;
        end else begin
            if (mask_we) begin
                mask_q <= mask_d;
            end
            case (state_q)
                IDLE: begin
                    if (|active) begin
                        sel_q   <= winner;
                        vec_q   <= win_vec;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        epc_q   <= pc_in;
                        state_q <= SERV;
                    end
                end
                SERV: begin
                    if (int_ret) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign int_req  = (state_q == REQ);
    assign int_busy = (state_q == SERV);
    assign int_vec  = vec_q;
    assign epc      = epc_q;

endmodule
